// File: rtl/multicore_in_dispatch.sv
// Input dispatcher: buffers tagged host words in a FIFO and hands each head word
// to exactly one requesting core (round-robin among matches) via a one-cycle grant.
module multicore_in_dispatch #(
  parameter int N     = 21,
  parameter int DW    = 31,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            host_data,
  input  logic [3:0]               host_ch,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [4*N-1:0]           req_in_bus,
  output logic [DW-1:0]            io_in,
  output logic [N-1:0]             in_grant,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [15:0]              drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [DW+3:0]      mem [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic [15:0]        drop_q;
  logic [IW-1:0]      rr_q, rr_d, win_q, win_d, win_sel;
  logic [N-1:0]       grant_q, grant_d;
  logic [DW-1:0]      io_q, io_d;
  logic               push, pop, drop_inc, found, empty;
  logic [3:0]         head_tag;
  logic [DW-1:0]      head_data;

  assign empty      = (cnt_q == '0);
  assign head_tag   = mem[rd_q][DW+3:DW];
  assign head_data  = mem[rd_q][DW-1:0];
  // Count never exceeds DEPTH, so its MSB alone flags "full".
  assign host_ready = rst & ~cnt_q[AW];
  assign push       = host_valid & host_ready;

  assign io_in    = io_q;
  assign in_grant = grant_q;
  assign fifo_cnt = cnt_q;
  assign drop_cnt = drop_q;

  // First core at or above rr_q (wrapping) whose request equals the head tag.
  always_comb begin : rr_search
    int j;
    j       = 0;
    found   = 1'b0;
    win_sel = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req_in_bus[4*j +: 4] == head_tag) begin
        found   = 1'b1;
        win_sel = j[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    drop_inc = 1'b0;
    grant_d  = '0;
    io_d     = io_q;
    win_d    = win_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_tag == 4'd0) begin
            pop      = 1'b1;
            drop_inc = 1'b1;
          end else if (found) begin
            win_d            = win_sel;
            grant_d[win_sel] = 1'b1;
            io_d             = head_data;
            state_d          = GRANT;
          end
        end
      end
      GRANT: begin
        pop     = 1'b1;
        rr_d    = (win_q == IW'(N-1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {host_ch, host_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      rr_q    <= '0;
      win_q   <= '0;
      grant_q <= '0;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      io_q    <= io_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end
endmodule
